// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start-bit detection, per-bit timing, deserializer
// strobes and start/parity/stop checking with byte-valid and error flags.
module uart_rx_fsm #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  par_run;
    logic                  bit_end;

    assign bit_end     = (state != IDLE) && (edge_cnt == (presc_q - PRESCALE_W'(1)));
    assign busy        = (state != IDLE);
    assign dat_samp_en = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the same-cycle deserializer strobe
    always_comb begin
        state_nxt = state;
        deser_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_in) state_nxt = START;
            end
            START: begin
                if (bit_end) state_nxt = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    deser_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, data bit index, running parity and frame status
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            par_run    <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            if (state == IDLE) begin
                if (!rx_in) begin
                    presc_q  <= prescale;
                    edge_cnt <= PRESCALE_W'(1);
                end else begin
                    edge_cnt <= '0;
                end
            end else if (bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (bit_end) begin
                case (state)
                    START: begin
                        if (!sampled_bit) begin
                            bit_cnt <= '0;
                            par_run <= 1'b0;
                            par_err <= 1'b0;
                            stp_err <= 1'b0;
                        end
                    end
                    DATA: begin
                        par_run <= par_run ^ sampled_bit;
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
                    end
                    PARITY: begin
                        par_err <= sampled_bit != (par_run ^ par_typ);
                    end
                    STOP: begin
                        stp_err    <= ~sampled_bit;
                        data_valid <= sampled_bit & ~par_err;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives whole frames cycle by cycle and checks
// timing of strobes, counters, busy and frame status against hand-derived values.
module tb_uart_rx_fsm;

    localparam int unsigned PRESCALE_W = 6;

    logic                  clk;
    logic                  rst;
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic                  sampled_bit;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  deser_en;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;
    int deser_seen = 0;
    logic m_perr = 1'b0;
    logic m_serr = 1'b0;

    uart_rx_fsm #(.PRESCALE_W(PRESCALE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle with new line/sampler values
    task automatic tick(input logic line, input logic samp);
        @(negedge clk);
        rx_in       = line;
        sampled_bit = samp;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},   32'(busy),        32'd0);
        chk({tag, "_samp"},   32'(dat_samp_en), 32'd0);
        chk({tag, "_deser"},  32'(deser_en),    32'd0);
        chk({tag, "_edge"},   32'(edge_cnt),    32'd0);
        chk({tag, "_bitcnt"}, 32'(bit_cnt),     32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b1);
            check_quiet("idle");
            chk("idle_dv",   32'(data_valid), 32'd0);
            chk("idle_perr", 32'(par_err),    32'(m_perr));
            chk("idle_serr", 32'(stp_err),    32'(m_serr));
        end
    endtask

    // Drives frame cycles start_c..last-1, checking every output each cycle
    task automatic run_frame(input int p, input logic [7:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic sbit, input int start_c,
                             input int end_c, input int p_mid);
        int total;
        int last;
        int b;
        logic line;
        logic perr_new;
        logic [7:0] sh;
        total    = (pe ? 11 : 10) * p;
        last     = (end_c < 0) ? total : end_c;
        perr_new = pe && (pbit != ((^d) ^ pt));
        sh       = 8'h00;
        par_en   = pe;
        par_typ  = pt;
        for (int c = start_c; c < last; c++) begin
            b = c / p;
            if (b == 0)      line = 1'b0;
            else if (b <= 8) line = d[b-1];
            else if (b == 9) line = pe ? pbit : sbit;
            else             line = sbit;
            @(negedge clk);
            if (c == 0) prescale = PRESCALE_W'(p);
            if (p_mid != 0 && c == 3 * p) prescale = PRESCALE_W'(p_mid);
            rx_in       = line;
            sampled_bit = line;
            #1;
            chk("busy",   32'(busy),        32'(c >= 1));
            chk("samp",   32'(dat_samp_en), 32'(c >= 1));
            chk("edge",   32'(edge_cnt),    32'(c % p));
            chk("bitcnt", 32'(bit_cnt),     32'((b >= 1 && b <= 8) ? b - 1 : 0));
            chk("deser",  32'(deser_en),    32'(b >= 1 && b <= 8 && (c % p) == p - 1));
            chk("dv",     32'(data_valid),  32'd0);
            chk("perr",   32'(par_err),     32'((c < p) ? m_perr : (pe && c >= 10 * p) ? perr_new : 1'b0));
            chk("serr",   32'(stp_err),     32'((c < p) ? m_serr : 1'b0));
            if (deser_en === 1'b1) begin
                sh = {sampled_bit, sh[7:1]};
                deser_seen++;
            end
        end
        if (last == total) chk("deser_byte", 32'(sh), 32'(d));
    endtask

    // First cycle after the stop bit: status visible, optionally starting the next frame
    task automatic check_end(input logic start_next, input logic dv, input logic pe_x, input logic se_x);
        tick(~start_next, 1'b1);
        chk("end_dv",   32'(data_valid), 32'(dv));
        chk("end_perr", 32'(par_err),    32'(pe_x));
        chk("end_serr", 32'(stp_err),    32'(se_x));
        check_quiet("end");
        m_perr = pe_x;
        m_serr = se_x;
    endtask

    initial begin
        int d0;
        rst         = 1'b1;
        rx_in       = 1'b1;
        sampled_bit = 1'b1;
        prescale    = PRESCALE_W'(8);
        par_en      = 1'b0;
        par_typ     = 1'b0;

        // Reset state
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("reset");
        chk("reset_dv",   32'(data_valid), 32'd0);
        chk("reset_perr", 32'(par_err),    32'd0);
        chk("reset_serr", 32'(stp_err),    32'd0);
        idle(3);

        // Plain frame 0xA5, P=8: deser at 15..71, data_valid at 80
        run_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Even parity 0xF0: good parity bit 0, then bad parity bit 1
        run_frame(8, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        run_frame(8, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1, 0);
        check_end(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Odd parity 0x07 (three ones): parity bit 0 is correct
        run_frame(8, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 0, -1, 0);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Stop error, then a good frame clears it at its start-bit end
        run_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        check_end(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        run_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Glitch: line low 3 cycles, start bit sampled high at its end (P=16)
        d0 = deser_seen;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) prescale = PRESCALE_W'(16);
            rx_in       = (c < 3) ? 1'b0 : 1'b1;
            sampled_bit = (c < 3) ? 1'b0 : 1'b1;
            #1;
            chk("gl_busy",  32'(busy),       32'(c >= 1 && c < 16));
            chk("gl_edge",  32'(edge_cnt),   32'((c >= 1 && c < 16) ? c : 0));
            chk("gl_deser", 32'(deser_en),   32'd0);
            chk("gl_dv",    32'(data_valid), 32'd0);
            chk("gl_serr",  32'(stp_err),    32'(m_serr));
        end
        idle(2);

        // Back-to-back 0x3C then 0xC3 at P=16: data_valid at 160 and 320
        d0 = deser_seen;
        run_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
        check_end(1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1, 0);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_deser_count", 32'(deser_seen - d0), 32'd16);
        idle(2);

        // Reset during data bit 4, then frame 0x55 with a mid-frame prescale change
        run_frame(8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 0, 43, 0);
        @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("rst_mid");
        chk("rst_mid_dv",   32'(data_valid), 32'd0);
        chk("rst_mid_perr", 32'(par_err),    32'd0);
        chk("rst_mid_serr", 32'(stp_err),    32'd0);
        m_perr = 1'b0;
        m_serr = 1'b0;
        idle(3);
        run_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 32);
        check_end(1'b0, 1'b1, 1'b0, 1'b0);
        prescale = PRESCALE_W'(8);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
